// File: rtl/l1_mem_rsp_router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : l1_mem_rsp_router_pkg
//  Description : Shared L1 cache response-routing definitions. The request
//                arbiter and the response router both derive the tag select
//                field width and the per-target select codes from here, so
//                the two ends of the memory path always agree.
//  Revision    : 1.0 - initial release
// ============================================================================
package l1_mem_rsp_router_pkg;

    // Width of the select field appended to the L1 tag. It never drops below
    // one bit, so a single-target build still carries a select bit.
    function automatic int sel_bits_for(input int num_outputs);
        return (num_outputs > 1) ? $clog2(num_outputs) : 1;
    endfunction

    localparam int NUM_L1_OUTPUTS  = 2;
    localparam int L1_RSP_SEL_BITS = sel_bits_for(NUM_L1_OUTPUTS);

    // Select codes per L1 target, with every cache enabled. The optional
    // caches take the next free code in enable order.
    typedef enum logic [2:0] {
        ICACHE_RSP_SEL = 3'd0,
        DCACHE_RSP_SEL = 3'd1,
        TCACHE_RSP_SEL = 3'd2,
        RCACHE_RSP_SEL = 3'd3,
        OCACHE_RSP_SEL = 3'd4
    } l1_rsp_target_e;

endpackage : l1_mem_rsp_router_pkg
`default_nettype wire

// File: rtl/l1_rsp_elastic_buf.sv
`default_nettype none
// ============================================================================
//  Module      : l1_rsp_elastic_buf
//  Description : DEPTH-entry FIFO with a registered occupancy count. The head
//                entry comes straight from the storage registers. o_full is
//                derived only from the registered count, so a pop in the same
//                cycle never makes room for a push.
//  Ports       : clk, reset (async, active-high)
//                i_push / i_data   - write side (ignored while full)
//                o_full            - registered-count full flag
//                o_valid / o_data  - head entry
//                i_ready           - consumer ready; pops when o_valid
//  Revision    : 1.0 - initial release
// ============================================================================
module l1_rsp_elastic_buf #(
    parameter int WIDTH = 528,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready
);

    localparam int                 c_ptr_w = $clog2(DEPTH);
    localparam int                 c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == c_depth);
    assign o_valid   = (r_count != '0);
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = o_valid & i_ready;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule : l1_rsp_elastic_buf
`default_nettype wire

// File: rtl/l1_mem_rsp_router.sv
`default_nettype none
// ============================================================================
//  Module      : l1_mem_rsp_router
//  Description : Routes single-stream memory responses back to the L1 caches.
//                The low SEL_BITS of the incoming tag choose the target; the
//                rest is the L1 tag handed to that target. Each target has
//                its own elastic buffer. Responses with an out-of-range
//                select are dropped, counted and flagged.
//  Ports       : clk, reset (async, active-high)
//                mem_rsp_valid/data/tag, mem_rsp_ready  - response input
//                l1_rsp_valid/data/tag, l1_rsp_ready    - per-target outputs,
//                                                         target i at slice i
//                bad_sel_count (saturating), bad_sel_err (sticky)
//                perf_rsp_count, perf_stall_cycles      - with perf enabled
//  Config      : define L1_RSP_ROUTER_PERF_EN to add the perf counters
//  Revision    : 1.0 - initial release
// ============================================================================
module l1_mem_rsp_router
    import l1_mem_rsp_router_pkg::*;
#(
    parameter  int NUM_OUTPUTS   = 2,
    parameter  int DATA_WIDTH    = 512,
    parameter  int TAG_OUT_WIDTH = 16,
    parameter  int BUF_DEPTH     = 2,
    parameter  int ERR_CNT_WIDTH = 8,
    localparam int SEL_BITS      = sel_bits_for(NUM_OUTPUTS),
    localparam int TAG_IN_WIDTH  = TAG_OUT_WIDTH + SEL_BITS
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]              mem_rsp_data,
    input  logic [TAG_IN_WIDTH-1:0]            mem_rsp_tag,
    output logic                               mem_rsp_ready,
    output logic [NUM_OUTPUTS-1:0]             l1_rsp_valid,
    output logic [NUM_OUTPUTS*DATA_WIDTH-1:0]  l1_rsp_data,
    output logic [NUM_OUTPUTS*TAG_OUT_WIDTH-1:0] l1_rsp_tag,
    input  logic [NUM_OUTPUTS-1:0]             l1_rsp_ready,
    output logic [ERR_CNT_WIDTH-1:0]           bad_sel_count,
    output logic                               bad_sel_err
`ifdef L1_RSP_ROUTER_PERF_EN
    ,
    output logic [NUM_OUTPUTS*32-1:0]          perf_rsp_count,
    output logic [31:0]                        perf_stall_cycles
`endif
);

    localparam int c_entry_w = DATA_WIDTH + TAG_OUT_WIDTH;
    // One extra bit so the range compare is never trivially constant when
    // NUM_OUTPUTS fills the select field.
    localparam logic [SEL_BITS:0] c_num_outputs = NUM_OUTPUTS[SEL_BITS:0];

    logic [SEL_BITS-1:0]      w_sel;
    logic                     w_sel_ok;
    logic                     w_bad_drop;
    logic [NUM_OUTPUTS-1:0]   w_sel_hit;
    logic [NUM_OUTPUTS-1:0]   w_full;
    logic [NUM_OUTPUTS-1:0]   w_push;
    logic [c_entry_w-1:0]     w_entry;

    logic [ERR_CNT_WIDTH-1:0] r_bad_sel_count;
    logic                     r_bad_sel_err;

    assign w_sel    = mem_rsp_tag[SEL_BITS-1:0];
    assign w_sel_ok = ({1'b0, w_sel} < c_num_outputs);
    assign w_entry  = {mem_rsp_data, mem_rsp_tag[TAG_IN_WIDTH-1:SEL_BITS]};

    // Bad selects are always accepted so they cannot wedge the return path.
    assign mem_rsp_ready = w_sel_ok ? |(w_sel_hit & ~w_full) : 1'b1;
    assign w_bad_drop    = mem_rsp_valid & ~w_sel_ok;

    generate
        for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_out
            logic [c_entry_w-1:0] w_head;

            assign w_sel_hit[i] = (w_sel == SEL_BITS'(i));
            assign w_push[i]    = mem_rsp_valid & w_sel_hit[i] & ~w_full[i];

            l1_rsp_elastic_buf #(
                .WIDTH (c_entry_w),
                .DEPTH (BUF_DEPTH)
            ) u_buf (
                .clk     (clk),
                .reset   (reset),
                .i_push  (w_push[i]),
                .i_data  (w_entry),
                .o_full  (w_full[i]),
                .o_valid (l1_rsp_valid[i]),
                .o_data  (w_head),
                .i_ready (l1_rsp_ready[i])
            );

            assign l1_rsp_data[i*DATA_WIDTH +: DATA_WIDTH]       = w_head[c_entry_w-1:TAG_OUT_WIDTH];
            assign l1_rsp_tag[i*TAG_OUT_WIDTH +: TAG_OUT_WIDTH]  = w_head[TAG_OUT_WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bad_sel_count <= '0;
            r_bad_sel_err   <= 1'b0;
        end else if (w_bad_drop) begin
            r_bad_sel_err <= 1'b1;
            if (r_bad_sel_count != '1) begin
                r_bad_sel_count <= r_bad_sel_count + 1'b1;
            end
        end
    end

    assign bad_sel_count = r_bad_sel_count;
    assign bad_sel_err   = r_bad_sel_err;

`ifdef L1_RSP_ROUTER_PERF_EN
    logic [31:0] r_perf_stall_cycles;

    generate
        for (genvar p = 0; p < NUM_OUTPUTS; p++) begin : g_perf
            logic [31:0] r_perf_rsp_count;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_perf_rsp_count <= '0;
                end else if (w_push[p]) begin
                    r_perf_rsp_count <= r_perf_rsp_count + 1'b1;
                end
            end

            assign perf_rsp_count[p*32 +: 32] = r_perf_rsp_count;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_stall_cycles <= '0;
        end else if (mem_rsp_valid && !mem_rsp_ready) begin
            r_perf_stall_cycles <= r_perf_stall_cycles + 1'b1;
        end
    end

    assign perf_stall_cycles = r_perf_stall_cycles;
`else
    // Perf counters are not built in this configuration.
`endif

endmodule : l1_mem_rsp_router
`default_nettype wire

// File: doc/l1_mem_rsp_router.md
Name: l1_mem_rsp_router

Overview:
- Return-path counterpart of the L1→L2 request arbitration. The arbiter appends output-select bits to the tag LSBs on the way down; this block does the reverse on the way back.
- It takes single-stream memory responses carrying the widened tag (L1_MEM_TAG_WIDTH + select bits). It strips the select field and routes each response to one of NUM_OUTPUTS L1 caches (icache, dcache, tcache, rcache, ocache) through per-output elastic buffers.
- It sits between the L2/L3 response port and the L1 memory-response inputs in each cluster.

Parameters:
- NUM_OUTPUTS, 2: number of L1 response targets (NUM_L1_OUTPUTS); legal range 1..8.
- DATA_WIDTH, 512: response data bits (L1 line size × 8).
- TAG_OUT_WIDTH, 16: tag width delivered to each L1 (L1_MEM_TAG_WIDTH).
- SEL_BITS, derived: CLOG2(NUM_OUTPUTS), minimum 1 when NUM_OUTPUTS=1.
- TAG_IN_WIDTH, derived: TAG_OUT_WIDTH + SEL_BITS.
- BUF_DEPTH, 2: entries per output buffer, power of 2, ≥2.
- ERR_CNT_WIDTH, 8: width of the bad-select counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- mem_rsp_valid  in  1  response valid
- mem_rsp_data  in  DATA_WIDTH  response data
- mem_rsp_tag  in  TAG_IN_WIDTH  tag; bits [SEL_BITS-1:0] are the select field, upper bits are the L1 tag
- mem_rsp_ready  out  1  response accepted
- l1_rsp_valid  out  NUM_OUTPUTS  per-output valid
- l1_rsp_data  out  NUM_OUTPUTS*DATA_WIDTH  per-output data, packed with output i at slice i
- l1_rsp_tag  out  NUM_OUTPUTS*TAG_OUT_WIDTH  per-output tag = mem_rsp_tag[TAG_IN_WIDTH-1:SEL_BITS]
- l1_rsp_ready  in  NUM_OUTPUTS  per-output ready
- bad_sel_count  out  ERR_CNT_WIDTH  saturating count of dropped responses
- bad_sel_err  out  1  sticky flag, set on the first drop

Behaviour:
- Reset (asynchronous, active-high, all state):
  - buffer counts and read/write pointers = 0
  - l1_rsp_valid = 0
  - bad_sel_count = 0, bad_sel_err = 0
  - perf counters = 0
  - Reset asserted mid-transfer discards all buffered entries; no partial output survives.
- Select decode: sel = mem_rsp_tag[SEL_BITS-1:0]. sel ≥ NUM_OUTPUTS is a bad select.
- Ready:
  - Valid sel: mem_rsp_ready = (count[sel] < BUF_DEPTH), using the registered count only. A same-cycle pop never enables a push, so there is no combinational path from l1_rsp_ready to mem_rsp_ready.
  - Bad sel: mem_rsp_ready = 1.
  - mem_rsp_ready may depend combinationally on mem_rsp_tag.
- Accept:
  - A handshake with a valid sel writes {data, tag_out} into buffer[sel].
  - A handshake with a bad sel drops the response, increments bad_sel_count (saturating at all-ones) and sets bad_sel_err.
- Output side:
  - l1_rsp_valid[i] = (count[i] != 0).
  - Head entry is driven from registers.
  - Pop when l1_rsp_valid[i] && l1_rsp_ready[i].
  - Minimum latency is 1 cycle (accepted at edge N, visible after edge N).
- Simultaneous push and pop on the same output: count unchanged; both pointers advance modulo BUF_DEPTH.
  - A full buffer with a pop blocks the push that cycle; the push succeeds the next cycle.
- Ordering: strict FIFO per output. No ordering relation across outputs.
- Outputs are independent: one stalled output blocks input only when the current head response targets it (head-of-line blocking is accepted by design).
- Data and tag outputs hold stable while valid && !ready.
- NUM_OUTPUTS=1: the select field is still present (SEL_BITS=1); sel=1 is a bad select.

Optional Feature:
- Macro: L1_RSP_ROUTER_PERF_EN.
- When defined, adds output perf_rsp_count (NUM_OUTPUTS*32) and perf_stall_cycles (32):
  - perf_rsp_count: per-output count of accepted responses.
  - perf_stall_cycles: cycles with mem_rsp_valid && !mem_rsp_ready.
  - Both wrap modulo 2^32 and reset to 0.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared cache package gains the following, reused by the request-side arbiter so both ends agree:
  - L1_RSP_SEL_BITS = CLOG2(NUM_L1_OUTPUTS)
  - Per-target select constants: ICACHE_RSP_SEL=0, DCACHE_RSP_SEL=1, then TCACHE/RCACHE/OCACHE in enable order.
- One sub-module: l1_rsp_elastic_buf, a BUF_DEPTH FIFO with registered count, instantiated NUM_OUTPUTS times.

Test Plan (NUM_OUTPUTS=3, SEL_BITS=2, TAG_OUT_WIDTH=8, BUF_DEPTH=2):
- Routing: push tag=0x15<<2|1 with data=0xA5, all readies high → output 1 valid one cycle later with tag=0x15, data=0xA5; outputs 0 and 2 stay invalid.
- Back-pressure: hold l1_rsp_ready[2]=0 and push 3 responses with sel=2 → first two accepted; mem_rsp_ready=0 on the third. Raise ready → the third is accepted the cycle after the first pop; delivery order preserved.
- Bad select: push sel=3 → ready=1, no output valid, bad_sel_count=1, bad_sel_err=1. Push 300 bad selects → count saturates at 255.
- Full push/pop: buffer 0 full with ready[0]=1 and a sel=0 push pending → push blocked that cycle, accepted next cycle, count never exceeds 2.
- Reset mid-operation: 2 entries in output 0 and 1 in output 1, assert reset asynchronously between edges → all l1_rsp_valid drop immediately; counters read 0 after release.
- Perf (macro defined): 5 responses to output 0, 4 stall cycles → perf_rsp_count[0]=5, perf_stall_cycles=4.
